// File: rtl/miriscv_mem_arbiter_pkg.sv
// rtl/miriscv_mem_arbiter_pkg.sv - owner encoding, response record and address check for the RAM arbiter
package miriscv_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   localparam int MEM_LATENCY = 1;

   typedef struct packed {
      owner_e owner;
      logic   err;
      logic   rd;
   } resp_t;

   // Word-aligned and inside the RAM; anything else is answered with an error response.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned ram_size);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < ram_size);
   endfunction

endpackage

// File: rtl/miriscv_mem_arbiter_prio.sv
// rtl/miriscv_mem_arbiter_prio.sv - data-first arbiter with a fetch starvation counter
module miriscv_arb_prio #(
   parameter int unsigned MAX_STALL = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       instr_req_i,
   input  logic       data_req_i,
   output logic [1:0] gnt_o
);

   logic [3:0] r_stall_cnt;
   logic       w_instr_gnt;
   logic       w_data_gnt;

   always_comb begin
      w_instr_gnt = 1'b0;
      w_data_gnt  = 1'b0;
      if (!rst_i) begin
         if (instr_req_i && (!data_req_i || r_stall_cnt == 4'(MAX_STALL))) begin
            w_instr_gnt = 1'b1;
         end else if (data_req_i) begin
            w_data_gnt = 1'b1;
         end
      end
   end

   assign gnt_o = {w_data_gnt, w_instr_gnt};

   // Counts consecutive cycles a waiting fetch was passed over; saturates rather than wraps.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= 4'd0;
      end else if (instr_req_i && !w_instr_gnt) begin
         if (r_stall_cnt != 4'hF) begin
            r_stall_cnt <= r_stall_cnt + 4'd1;
         end
      end else begin
         r_stall_cnt <= 4'd0;
      end
   end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - shares one RAM port between fetch and load/store
// Optional grant/conflict counters under MIRISCV_MEM_ARB_STATS_EN.
module miriscv_mem_arbiter
   import miriscv_mem_pkg::*;
#(
   parameter int unsigned RAM_SIZE  = 512,
   parameter int unsigned MAX_STALL = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
`ifdef MIRISCV_MEM_ARB_STATS_EN
   ,
   output logic [31:0] stat_instr_gnt_o,
   output logic [31:0] stat_data_gnt_o,
   output logic [31:0] stat_conflict_o
`endif
);

   logic [1:0]  w_gnt;
   logic        w_instr_gnt;
   logic        w_data_gnt;
   logic        w_instr_ok;
   logic        w_data_ok;
   resp_t       w_resp_next;
   resp_t       w_resp_out;
   logic [31:0] w_rd_data;
   resp_t       r_resp [MEM_LATENCY];

   miriscv_arb_prio #(
      .MAX_STALL(MAX_STALL)
   ) u_prio (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .instr_req_i(instr_req_i),
      .data_req_i (data_req_i),
      .gnt_o      (w_gnt)
   );

   assign w_instr_gnt = w_gnt[0];
   assign w_data_gnt  = w_gnt[1];
   assign instr_gnt_o = w_instr_gnt;
   assign data_gnt_o  = w_data_gnt;

   assign w_instr_ok = addr_in_range(instr_addr_i, RAM_SIZE);
   assign w_data_ok  = addr_in_range(data_addr_i, RAM_SIZE);

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'b0000;
      mem_addr_o  = 32'd0;
      mem_wdata_o = 32'd0;
      w_resp_next = '0;
      if (w_data_gnt) begin
         mem_req_o         = w_data_ok;
         mem_we_o          = data_we_i && w_data_ok;
         mem_be_o          = data_be_i;
         mem_addr_o        = {2'b00, data_addr_i[31:2]};
         mem_wdata_o       = data_wdata_i;
         w_resp_next.owner = OWN_DATA;
         w_resp_next.err   = !w_data_ok;
         w_resp_next.rd    = w_data_ok && !data_we_i;
      end else if (w_instr_gnt) begin
         mem_req_o         = w_instr_ok;
         mem_be_o          = 4'b1111;
         mem_addr_o        = {2'b00, instr_addr_i[31:2]};
         w_resp_next.owner = OWN_INSTR;
         w_resp_next.err   = !w_instr_ok;
         w_resp_next.rd    = w_instr_ok;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < MEM_LATENCY; i++) begin
            r_resp[i] <= '0;
         end
      end else begin
         r_resp[0] <= w_resp_next;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            r_resp[i] <= r_resp[i-1];
         end
      end
   end

   // Gating with rst_i drops a response that is in flight when reset arrives.
   assign w_resp_out     = r_resp[MEM_LATENCY-1];
   assign w_rd_data      = w_resp_out.rd ? mem_rdata_i : 32'd0;
   assign instr_rvalid_o = !rst_i && (w_resp_out.owner == OWN_INSTR);
   assign instr_err_o    = instr_rvalid_o && w_resp_out.err;
   assign instr_rdata_o  = instr_rvalid_o ? w_rd_data : 32'd0;
   assign data_rvalid_o  = !rst_i && (w_resp_out.owner == OWN_DATA);
   assign data_err_o     = data_rvalid_o && w_resp_out.err;
   assign data_rdata_o   = data_rvalid_o ? w_rd_data : 32'd0;

`ifdef MIRISCV_MEM_ARB_STATS_EN
   logic [31:0] r_stat_instr;
   logic [31:0] r_stat_data;
   logic [31:0] r_stat_conflict;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stat_instr    <= 32'd0;
         r_stat_data     <= 32'd0;
         r_stat_conflict <= 32'd0;
      end else begin
         if (w_instr_gnt) begin
            r_stat_instr <= r_stat_instr + 32'd1;
         end
         if (w_data_gnt) begin
            r_stat_data <= r_stat_data + 32'd1;
         end
         if (instr_req_i && data_req_i) begin
            r_stat_conflict <= r_stat_conflict + 32'd1;
         end
      end
   end

   assign stat_instr_gnt_o = r_stat_instr;
   assign stat_data_gnt_o  = r_stat_data;
   assign stat_conflict_o  = r_stat_conflict;
`endif

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb/tb_miriscv_mem_arbiter.sv - table-driven and randomized bench for miriscv_mem_arbiter
`timescale 1ns/1ps
module tb_miriscv_mem_arbiter;

   localparam int unsigned RAM_SIZE  = 512;
   localparam int unsigned MAX_STALL = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = 32'd0;
`ifdef MIRISCV_MEM_ARB_STATS_EN
   logic [31:0] stat_instr_gnt_o;
   logic [31:0] stat_data_gnt_o;
   logic [31:0] stat_conflict_o;
`endif

   always #5 clk = ~clk;

   miriscv_mem_arbiter #(
      .RAM_SIZE (RAM_SIZE),
      .MAX_STALL(MAX_STALL)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .instr_req_i   (instr_req_i),
      .instr_addr_i  (instr_addr_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o (instr_rdata_o),
      .instr_err_o   (instr_err_o),
      .data_req_i    (data_req_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_gnt_o    (data_gnt_o),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .data_err_o    (data_err_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_be_o      (mem_be_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata_i)
`ifdef MIRISCV_MEM_ARB_STATS_EN
      ,
      .stat_instr_gnt_o(stat_instr_gnt_o),
      .stat_data_gnt_o (stat_data_gnt_o),
      .stat_conflict_o (stat_conflict_o)
`endif
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // RAM the arbiter drives: one-cycle read latency, byte-enabled writes.
   logic [31:0] ram [RAM_SIZE];
   always @(posedge clk) begin
      if (mem_req_o) begin
         if (mem_we_o) ram[mem_addr_o[8:0]] <= merge(ram[mem_addr_o[8:0]], mem_wdata_o, mem_be_o);
         else          mem_rdata_i <= ram[mem_addr_o[8:0]];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [RAM_SIZE];
   int          m_stall;
   int          m_owner;
   bit          m_err;
   logic [31:0] m_rdata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return ((a / 4) < RAM_SIZE) && ((a % 4) == 0);
   endfunction

   task automatic predict(output bit eig, output bit edg);
      eig = 1'b0;
      edg = 1'b0;
      if (!rst_i) begin
         if (instr_req_i && data_req_i) begin
            if (m_stall >= int'(MAX_STALL)) eig = 1'b1;
            else                             edg = 1'b1;
         end else if (instr_req_i) eig = 1'b1;
         else if (data_req_i)      edg = 1'b1;
      end
   endtask

   task automatic model_check();
      bit eig, edg, emreq;
      predict(eig, edg);
      emreq = (eig && in_range(instr_addr_i)) || (edg && in_range(data_addr_i));
      chk("instr_gnt", 32'(instr_gnt_o), 32'(eig));
      chk("data_gnt", 32'(data_gnt_o), 32'(edg));
      chk("mem_req", 32'(mem_req_o), 32'(emreq));
      if (emreq) begin
         chk("mem_addr", mem_addr_o, (eig ? instr_addr_i : data_addr_i) / 4);
         chk("mem_we", 32'(mem_we_o), 32'(edg && data_we_i));
         chk("mem_be", 32'(mem_be_o), edg ? 32'(data_be_i) : 32'hF);
         if (edg && data_we_i) chk("mem_wdata", mem_wdata_o, data_wdata_i);
      end
      if (rst_i) chk("mem_idle_in_rst", 32'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} != '0), 32'd0);
      chk("instr_rvalid", 32'(instr_rvalid_o), 32'(!rst_i && m_owner == 1));
      chk("data_rvalid", 32'(data_rvalid_o), 32'(!rst_i && m_owner == 2));
      if (rst_i || m_owner == 1) begin
         chk("instr_err", 32'(instr_err_o), 32'(!rst_i && m_err));
         chk("instr_rdata", instr_rdata_o, rst_i ? 32'd0 : m_rdata);
      end
      if (rst_i || m_owner == 2) begin
         chk("data_err", 32'(data_err_o), 32'(!rst_i && m_err));
         chk("data_rdata", data_rdata_o, rst_i ? 32'd0 : m_rdata);
      end
   endtask

   task automatic model_advance();
      bit eig, edg;
      logic [31:0] a;
      int w;
      predict(eig, edg);
      if (rst_i) begin
         m_stall = 0; m_owner = 0; m_err = 1'b0; m_rdata = 32'd0;
         return;
      end
      m_stall = (instr_req_i && !eig) ? ((m_stall < 15) ? m_stall + 1 : 15) : 0;
      m_owner = eig ? 1 : (edg ? 2 : 0);
      a       = eig ? instr_addr_i : data_addr_i;
      m_err   = !in_range(a);
      m_rdata = 32'd0;
      if ((eig || edg) && in_range(a)) begin
         w = int'(a / 4);
         if (edg && data_we_i) ref_mem[w] = merge(ref_mem[w], data_wdata_i, data_be_i);
         else                  m_rdata = ref_mem[w];
      end
   endtask

   task automatic end_cycle();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle(input bit rst);
      rst_i = rst; instr_req_i = 1'b0; instr_addr_i = 32'd0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'd0; data_wdata_i = 32'd0;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 32'h800 + (32'($urandom_range(0, 255)) << 2);
      if (r == 1) return (32'($urandom_range(0, 511)) << 2) | 32'($urandom_range(1, 3));
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   typedef struct {
      int rst; int ireq; logic [31:0] iaddr;
      int dreq; int dwe; logic [3:0] dbe; logic [31:0] daddr; logic [31:0] dwdata;
      int ig; int dg; int mreq;
      int iv; logic [31:0] ird;
      int dv; int de; logic [31:0] drd;
   } vec_t;

   vec_t vecs[$];

   initial begin
      bit eig, edg, i_hold, d_hold;
      for (int i = 0; i < int'(RAM_SIZE); i++) begin
         ram[i]     = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
         ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      end
      ram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
      ram[8] = 32'hAAAAAAAA; ref_mem[8] = 32'hAAAAAAAA;
      m_stall = 0; m_owner = 0; m_err = 1'b0; m_rdata = 32'd0;
      set_idle(1'b1);
      @(posedge clk);
      #1;

      //            rst ireq iaddr        dreq dwe dbe      daddr    dwdata        ig dg mrq iv ird            dv de drd
      vecs.push_back(vec_t'{1, 1, 32'h10, 1, 0, 4'h0,    32'h40,  32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 32'h10, 0, 0, 4'h0,    32'h0,   32'h0,        1, 0, 1, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  0, 0, 4'h0,    32'h0,   32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  1, 1, 4'b0011, 32'h20,  32'h12345678, 0, 1, 1, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 32'h20, 0, 0, 4'h0,    32'h0,   32'h0,        1, 0, 1, 0, 32'h0,        1, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  0, 0, 4'h0,    32'h0,   32'h0,        0, 0, 0, 1, 32'hAAAA5678, 0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  1, 0, 4'hF,    32'h800, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  1, 0, 4'hF,    32'h2,   32'h0,        0, 1, 0, 0, 32'h0,        1, 1, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  0, 0, 4'h0,    32'h0,   32'h0,        0, 0, 0, 0, 32'h0,        1, 1, 32'h0});
      vecs.push_back(vec_t'{0, 1, 32'h24, 1, 1, 4'hF,    32'h24,  32'hCAFEF00D, 0, 1, 1, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 32'h24, 0, 0, 4'h0,    32'h0,   32'h0,        1, 0, 1, 0, 32'h0,        1, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  0, 0, 4'h0,    32'h0,   32'h0,        0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 32'h10, 0, 0, 4'h0,    32'h0,   32'h0,        1, 0, 1, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{1, 1, 32'h10, 0, 0, 4'h0,    32'h0,   32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  0, 0, 4'h0,    32'h0,   32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 32'h10, 0, 0, 4'h0,    32'h0,   32'h0,        1, 0, 1, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 0, 32'h0,  0, 0, 4'h0,    32'h0,   32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0});

      foreach (vecs[i]) begin
         rst_i = (vecs[i].rst != 0); instr_req_i = (vecs[i].ireq != 0); instr_addr_i = vecs[i].iaddr;
         data_req_i = (vecs[i].dreq != 0); data_we_i = (vecs[i].dwe != 0); data_be_i = vecs[i].dbe;
         data_addr_i = vecs[i].daddr; data_wdata_i = vecs[i].dwdata;
         @(negedge clk);
         chk($sformatf("v%0d_instr_gnt", i), 32'(instr_gnt_o), 32'(vecs[i].ig));
         chk($sformatf("v%0d_data_gnt", i), 32'(data_gnt_o), 32'(vecs[i].dg));
         chk($sformatf("v%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].mreq));
         chk($sformatf("v%0d_instr_rvalid", i), 32'(instr_rvalid_o), 32'(vecs[i].iv));
         chk($sformatf("v%0d_data_rvalid", i), 32'(data_rvalid_o), 32'(vecs[i].dv));
         if (vecs[i].iv != 0) chk($sformatf("v%0d_instr_rdata", i), instr_rdata_o, vecs[i].ird);
         if (vecs[i].dv != 0) begin
            chk($sformatf("v%0d_data_err", i), 32'(data_err_o), 32'(vecs[i].de));
            chk($sformatf("v%0d_data_rdata", i), data_rdata_o, vecs[i].drd);
         end
         model_check();
         end_cycle();
      end

      // Sustained contention: fetch must win exactly every (MAX_STALL+1)th cycle.
      set_idle(1'b1);
      @(negedge clk); model_check(); end_cycle();
      set_idle(1'b0);
      instr_req_i = 1'b1; instr_addr_i = 32'h10;
      data_req_i = 1'b1; data_addr_i = 32'h20; data_be_i = 4'hF;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("contend%0d_instr_gnt", k), 32'(instr_gnt_o), 32'((k % 5) == 4));
         chk($sformatf("contend%0d_data_gnt", k), 32'(data_gnt_o), 32'((k % 5) != 4));
         model_check();
         end_cycle();
      end
`ifdef MIRISCV_MEM_ARB_STATS_EN
      chk("stat_conflict", stat_conflict_o, 32'd10);
      chk("stat_data_gnt", stat_data_gnt_o, 32'd8);
      chk("stat_instr_gnt", stat_instr_gnt_o, 32'd2);
`endif
      set_idle(1'b0);
      @(negedge clk); model_check(); end_cycle();

      // Random traffic; a requester that loses keeps its request and fields stable.
      i_hold = 1'b0;
      d_hold = 1'b0;
      for (int c = 0; c < 600; c++) begin
         rst_i = ($urandom_range(0, 99) == 0);
         if (!i_hold) begin
            instr_req_i  = ($urandom_range(0, 2) != 0);
            instr_addr_i = rand_addr();
         end
         if (!d_hold) begin
            data_req_i   = ($urandom_range(0, 2) != 0);
            data_we_i    = ($urandom_range(0, 1) != 0);
            data_be_i    = 4'($urandom_range(1, 15));
            data_addr_i  = rand_addr();
            data_wdata_i = $urandom();
         end
         @(negedge clk);
         model_check();
         predict(eig, edg);
         i_hold = !rst_i && instr_req_i && !eig;
         d_hold = !rst_i && data_req_i && !edg;
         end_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
